// File: rtl/cc_line_deserializer_if.sv
// Bundle of request, R-beat and fill signals between the deserializer and its neighbours.
// The slave modport is the deserializer's view; master is the environment's view.
interface cc_line_deserializer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int INFO_WIDTH = 26
);
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [2:0]              req_offset_i;
  logic [INFO_WIDTH-1:0]   req_info_i;
  logic [DATA_WIDTH-1:0]   in_rdata_i;
  logic                    in_rlast_i;
  logic                    in_rvalid_i;
  logic                    in_rready_o;
  logic                    fill_valid_o;
  logic                    fill_ready_i;
  logic [8*DATA_WIDTH-1:0] fill_data_o;
  logic [INFO_WIDTH-1:0]   fill_info_o;
  logic                    err_o;

  modport slave (
    input  req_valid_i, req_offset_i, req_info_i,
    input  in_rdata_i, in_rlast_i, in_rvalid_i,
    input  fill_ready_i,
    output req_ready_o, in_rready_o,
    output fill_valid_o, fill_data_o, fill_info_o, err_o
  );

  modport master (
    output req_valid_i, req_offset_i, req_info_i,
    output in_rdata_i, in_rlast_i, in_rvalid_i,
    output fill_ready_i,
    input  req_ready_o, in_rready_o,
    input  fill_valid_o, fill_data_o, fill_info_o, err_o
  );
endinterface

// File: rtl/cc_line_deserializer.sv
// Reassembles eight wrap-ordered R beats into one cache line paired with its miss request info.
// Optional burst-framing check on rlast is built only when CC_DESER_LAST_CHECK_EN is defined.
module cc_line_deserializer #(
  parameter int DATA_WIDTH = 64,
  parameter int INFO_WIDTH = 26
) (
  input logic                  clk,
  input logic                  rst,
  cc_line_deserializer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]            r_q_offset [2];
  logic [INFO_WIDTH-1:0] r_q_info   [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic [2:0]            r_k;
  logic [DATA_WIDTH-1:0] r_words [8];

  logic       w_push;
  logic       w_pop;
  logic       w_beat_hs;
  logic [2:0] w_slot;
  logic       w_in_rready;
  logic       w_fill_valid;

  assign w_push    = bus.req_valid_i && (r_count != 2'd2);
  assign w_pop     = w_fill_valid && bus.fill_ready_i;
  assign w_beat_hs = w_in_rready && bus.in_rvalid_i;
  // Critical word first: beat k lands at the request's offset plus k, wrapping in the line.
  assign w_slot    = r_q_offset[r_rd_ptr] + r_k;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_count != 2'd0) begin
          w_state_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_beat_hs && (r_k == 3'd7)) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        // A push in the same cycle as the pop still leaves work queued.
        if (w_pop) begin
          w_state_next = ((r_count > 2'd1) || w_push) ? S_COLLECT : S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_in_rready  = 1'b0;
    w_fill_valid = 1'b0;
    case (r_state)
      S_COLLECT: w_in_rready  = 1'b1;
      S_HOLD:    w_fill_valid = 1'b1;
      default: begin
        w_in_rready  = 1'b0;
        w_fill_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_queue
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q_offset[gi] <= 3'd0;
          r_q_info[gi]   <= '0;
        end else if (w_push && (r_wr_ptr == 1'(gi))) begin
          r_q_offset[gi] <= bus.req_offset_i;
          r_q_info[gi]   <= bus.req_info_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k <= 3'd0;
    end else if (r_state == S_IDLE) begin
      r_k <= 3'd0;
    end else if (w_beat_hs) begin
      r_k <= r_k + 3'd1;
    end
  end

  // Every slot is rewritten each burst, so the buffer is never cleared between lines.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      always_ff @(posedge clk) begin
        if (rst) begin
          r_words[gi] <= '0;
        end else if (w_beat_hs && (w_slot == 3'(gi))) begin
          r_words[gi] <= bus.in_rdata_i;
        end
      end
      assign bus.fill_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_words[gi];
    end
  endgenerate

`ifdef CC_DESER_LAST_CHECK_EN
  logic r_err;

  // rlast must coincide exactly with the eighth beat; completion still follows k alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_beat_hs && (bus.in_rlast_i != (r_k == 3'd7))) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_o = r_err;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.req_ready_o  = (r_count != 2'd2);
  assign bus.in_rready_o  = w_in_rready;
  assign bus.fill_valid_o = w_fill_valid;
  assign bus.fill_info_o  = r_q_info[r_rd_ptr];

endmodule
